// File: rtl/apb_pkg.sv
// Shared APB master types: transfer FSM states, request/response records,
// and the timeout counter width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_DATA_W     = 32;
  localparam int APB_MAX_ADDR_W = 32;

  typedef struct packed {
    logic                      write;
    logic [APB_MAX_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0]     wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Width of a counter that must reach n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_req_master.sv
// APB initiator: one valid/ready request becomes one APB transfer and one
// response. Handles wait states, PSLVERR and an optional PREADY timeout.
//
// Handshakes: a beat transfers on a rising HCLK edge where valid and ready
// are both high; valid, once raised, holds its payload until that edge.
module apb_req_master
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output apb_state_e                dbg_state
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  apb_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic                      pwrite_q;
  apb_rsp_t                  rsp_q;
  logic                      req_fire;
  logic                      done;
  logic                      timeout_hit;

  // In RESP a new request can only be taken together with the response.
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign req_fire  = req_valid && req_ready;
  assign done      = (state_q == ACCESS) && PREADY;

  // Fires on the wait cycle whose increment would reach the limit;
  // a completion in the same cycle takes priority.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) && !PREADY &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = req_valid ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        paddr_q  <= req_addr;
        pwdata_q <= req_wdata;
        pwrite_q <= req_write;
        cnt_q    <= '0;
      end else if ((state_q == ACCESS) && !PREADY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (done) begin
        rsp_q.rdata   <= (!pwrite_q && !PSLVERR) ? PRDATA : 32'h0;
        rsp_q.err     <= PSLVERR;
        rsp_q.timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_q.rdata   <= 32'h0;
        rsp_q.err     <= 1'b1;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: a table of single transfers plus
// hand-written backpressure, back-to-back and mid-transfer reset sequences.
module tb_apb_req_master;
  import apb_pkg::*;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;
  apb_state_e    dbg_state;

  always #5 HCLK = ~HCLK;

  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   prdata;
    logic          pslverr;
    int            waits;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_lat;
    int            exp_pen;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One complete transfer from IDLE; waits = PREADY-low ACCESS cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, acc, lat;
    logic addr_ok, setup_ok;
    @(negedge HCLK);
    check($sformatf("v%0d_idle_ready", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = v.pslverr; PRDATA = 32'hBAD0_0000;
    @(negedge HCLK);
    req_valid = 1'b0; req_write = ~v.write; req_addr = ~v.addr; req_wdata = ~v.wdata;
    cyc = 1; acc = 0; lat = -1; addr_ok = 1'b1; setup_ok = 1'b0;
    while (cyc < 40 && lat < 0) begin
      if (rsp_valid) lat = cyc;
      else begin
        if (cyc == 1) setup_ok = PSEL && !PENABLE;
        if (PSEL && (PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.write))
          addr_ok = 1'b0;
        if (PSEL && PENABLE) begin
          acc++;
          PREADY = (acc > v.waits);
          PRDATA = PREADY ? v.prdata : (32'hBAD0_0000 | 32'(acc));
        end else PREADY = 1'b0;
        @(negedge HCLK);
        cyc++;
      end
    end
    PREADY = 1'b0;
    check($sformatf("v%0d_setup_c1", idx), 32'(setup_ok), 32'd1);
    check($sformatf("v%0d_pbus_stable", idx), 32'(addr_ok), 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_penable_cycles", idx), 32'(acc), 32'(v.exp_pen));
    check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d_timeout", idx), 32'(rsp_timeout), 32'(v.exp_to));
    check($sformatf("v%0d_resp_req_ready", idx), 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_drained", idx), {30'd0, rsp_valid, PSEL}, 32'd0);
    check($sformatf("v%0d_back_idle", idx), 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   gap;
    logic [31:0] held;
    logic stale;

    //          wr    addr     wdata         prdata        err  wt    rdata         e     t     lat pen
    vecs[0] = '{1'b1, 12'h008, 32'h0000_00FF, 32'h1111_1111, 1'b0, 0,    32'h0,        1'b0, 1'b0, 3,  1};
    vecs[1] = '{1'b0, 12'h004, 32'h0,         32'hA5A5_0001, 1'b0, 3,    32'hA5A5_0001, 1'b0, 1'b0, 6,  4};
    vecs[2] = '{1'b0, 12'h03C, 32'h0,         32'hDEAD_BEEF, 1'b1, 0,    32'h0,        1'b1, 1'b0, 3,  1};
    vecs[3] = '{1'b1, 12'h010, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 2,    32'h0,        1'b1, 1'b0, 5,  3};
    vecs[4] = '{1'b0, 12'h020, 32'h0,         32'h7777_7777, 1'b0, 1000, 32'h0,        1'b1, 1'b1, 18, 16};
    vecs[5] = '{1'b0, 12'h024, 32'h0,         32'h1234_ABCD, 1'b0, 0,    32'h1234_ABCD, 1'b0, 1'b0, 3,  1};
    vecs[6] = '{1'b0, 12'hFFC, 32'h0,         32'hCAFE_F00D, 1'b0, 15,   32'hCAFE_F00D, 1'b0, 1'b0, 18, 16};
    vecs[7] = '{1'b1, 12'h800, 32'hA0A0_0505, 32'h5555_5555, 1'b0, 1,    32'h0,        1'b0, 1'b0, 4,  2};

    // Reset values, checked while reset is still asserted.
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_bus_ctl", {28'd0, PSEL, PENABLE, PWRITE, rsp_valid}, 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_rsp", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Response backpressure, then back-to-back transfers.
    @(negedge HCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h100; req_wdata = 32'h0;
    PRDATA = 32'h0BAD_F00D; PSLVERR = 1'b0; PREADY = 1'b1; rsp_ready = 1'b0;
    @(negedge HCLK);
    req_write = 1'b1; req_addr = 12'h104; req_wdata = 32'h0000_0055;
    @(negedge HCLK);
    @(negedge HCLK);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rdata", rsp_rdata, 32'h0BAD_F00D);
    held = rsp_rdata;
    stale = 1'b0;
    repeat (5) begin
      if (rsp_rdata !== held || req_ready !== 1'b0 || PSEL !== 1'b0 || rsp_valid !== 1'b1)
        stale = 1'b1;
      @(negedge HCLK);
    end
    check("bp_hold_5cyc", 32'(stale), 32'd0);
    rsp_ready = 1'b1;
    #1 check("bp_req_ready_follows", 32'(req_ready), 32'd1);
    @(negedge HCLK);
    check("b2b_setup_next", {29'd0, PSEL, PENABLE, rsp_valid}, 32'b100);
    check("b2b_paddr", 32'(PADDR), 32'h104);
    check("b2b_pwrite", 32'(PWRITE), 32'd1);
    gap = 0;
    do begin
      @(negedge HCLK);
      gap++;
      if (rsp_valid) check("b2b_write_rdata", rsp_rdata, 32'h0);
    end while (!(PSEL && !PENABLE) && gap < 10);
    check("b2b_spacing", 32'(gap), 32'd3);
    req_valid = 1'b0;
    repeat (3) @(negedge HCLK);
    check("b2b_drain_idle", 32'(dbg_state), 32'(IDLE));
    rsp_ready = 1'b0; PREADY = 1'b0;

    // Reset in the middle of ACCESS.
    @(negedge HCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h0AA;
    @(negedge HCLK);
    req_valid = 1'b0;
    @(negedge HCLK);
    check("mid_in_access", 32'(PENABLE), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_bus_drop", {30'd0, PSEL, PENABLE}, 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1; PREADY = 1'b1; PRDATA = 32'h5EE5_5EE5;
    check("mid_rel_req_ready", 32'(req_ready), 32'd1);
    stale = 1'b0;
    repeat (5) begin
      @(negedge HCLK);
      if (rsp_valid || PSEL) stale = 1'b1;
    end
    check("mid_no_stale_rsp", 32'(stale), 32'd0);
    PREADY = 1'b0;
    run_vec(vecs[1], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
# apb_req_master

APB initiator that turns a valid/ready request stream into single APB transfers and returns one response per request. It is the bus-master counterpart of the peripheral APB slaves such as GPIO, UART and timer, and sits between a simple command source (debug bridge, DMA-lite, test sequencer) and the APB slave fabric. It handles slave wait states (PREADY), error responses (PSLVERR), and an optional hang timeout. One transfer is outstanding at a time.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12: width of PADDR and req_addr.
- TIMEOUT_CYCLES, 0: maximum ACCESS cycles waiting for PREADY; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- HCLK, input, 1: single clock. All logic is on the rising edge.
- HRESETn, input, 1: reset, asynchronous, active-low.
- req_valid, input, 1: request present.
- req_ready, output, 1: request accepted when high together with req_valid.
- req_write, input, 1: 1 = write, 0 = read.
- req_addr, input, APB_ADDR_WIDTH: byte address, passed through unmodified.
- req_wdata, input, 32: write data.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: response consumed when high together with rsp_valid.
- rsp_rdata, output, 32: read data; 0 for writes, errors and timeouts.
- rsp_err, output, 1: PSLVERR was sampled, or a timeout occurred.
- rsp_timeout, output, 1: the transfer was aborted by the timeout.
- PADDR, output, APB_ADDR_WIDTH.
- PWDATA, output, 32.
- PWRITE, output, 1.
- PSEL, output, 1.
- PENABLE, output, 1.
- PRDATA, input, 32.
- PREADY, input, 1.
- PSLVERR, input, 1.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**: req_ready=1. On handshake, register req_addr, req_wdata and req_write into PADDR, PWDATA and PWRITE, then go to SETUP.
- **SETUP**: PSEL=1, PENABLE=0. Always moves to ACCESS after one cycle.
- **ACCESS**: PSEL=1, PENABLE=1. The timeout counter increments each cycle PREADY=0.
  - PREADY=1: capture rsp_rdata (PRDATA if read and PSLVERR=0, else 0), rsp_err=PSLVERR, rsp_timeout=0. Go to RESP.
  - Otherwise, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP. PSEL and PENABLE drop on the next edge.
- **RESP**: rsp_valid=1, PSEL=0, PENABLE=0. Response fields hold until rsp_ready. req_ready = rsp_ready.
  - rsp_ready=1 and req_valid=1: consume the response, latch the new request, go to SETUP.
  - rsp_ready=1 and req_valid=0: go to IDLE.
  - rsp_ready=0: stay in RESP.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS. Outside a transfer they keep their last value.
- PREADY, PRDATA and PSLVERR are ignored outside ACCESS.
- The timeout counter clears on entry to SETUP.
- Simultaneous events:
  - PREADY=1 on the same cycle the counter would hit the limit: the completion wins, with no timeout flag.
  - rsp_ready and req_valid both high in RESP: both handshakes occur in that cycle.

## Timing
- Reset values: req_ready=1 (state IDLE); all other outputs 0; PADDR=0, PWDATA=0.
- Reset asserted mid-transfer: PSEL and PENABLE drop asynchronously, the transfer and any pending response are discarded, and the FSM returns to IDLE.
- Zero-wait-state latency, with request handshake at edge 0:
  - SETUP in cycle 1.
  - ACCESS in cycle 2.
  - rsp_valid in cycle 3.
- Each PREADY-low cycle adds one cycle of latency.
- Maximum throughput is one transfer per 3 cycles (RESP→SETUP→ACCESS) when the requester and consumer both stay ready.
- All outputs are registered, or decoded directly from state registers. No combinational path runs from PREADY or PRDATA to any output. req_ready depends combinationally on rsp_ready only in RESP.

## Structure
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS, RESP}.
  - Request struct {write, addr, wdata}.
  - Response struct {rdata, err, timeout}.
  - These are reused by future APB masters.
- No sub-module; the block is a single FSM plus the timeout counter.

## Test plan
- **Zero-wait write:** write 0x0000_00FF to 0x008, PREADY=1.
  - Required: PSEL=1/PENABLE=0 in cycle 1; PSEL=1/PENABLE=1 in cycle 2; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- **Wait-state read:** read 0x004, PREADY low for 3 ACCESS cycles, PRDATA=0xA5A5_0001.
  - Required: PADDR stable throughout; rsp_valid in cycle 6; rsp_rdata=0xA5A5_0001.
- **Slave error:** read 0x03C with PSLVERR=1 and PREADY=1.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- **Timeout:** TIMEOUT_CYCLES=16, PREADY held 0.
  - Required: PENABLE high for exactly 16 cycles, then rsp_err=1 and rsp_timeout=1.
  - Next request completes normally.
- **Backpressure and back-to-back:**
  - rsp_ready low for 5 cycles: response fields stable, req_ready=0, no new PSEL.
  - Then rsp_ready and req_valid held high: the new SETUP follows in the very next cycle, giving 3-cycle spacing.
- **Reset mid-ACCESS:** assert HRESETn=0 during ACCESS.
  - Required: PSEL and PENABLE go to 0 immediately, rsp_valid=0, req_ready=1 after release, and no stale response appears.
